// File: rtl/stack_cpu_p.sv
// stack_cpu_p: parametrised stack processor core.
// The data stack is held internally; program and data memory sit outside
// the core behind a synchronous-read port. The core has ready/valid input and
// output handshakes, CALL/RET, and a sticky fault state that is entered on
// stack overflow, stack underflow or an illegal opcode.
module stack_cpu_p #(
   parameter int DW    = 16,
   parameter int AW    = 12,
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   run_i,
   input  logic [DW-1:0]          in_data_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic [DW-1:0]          out_data_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [AW-1:0]          mem_addr_o,
   output logic                   mem_re_o,
   input  logic [DW-1:0]          mem_rdata_i,
   output logic                   mem_we_o,
   output logic [DW-1:0]          mem_wdata_o,
   output logic [AW-1:0]          pc_o,
   output logic [DW-1:0]          ir_o,
   output logic [DW-1:0]          qtop_o,
   output logic [$clog2(DEPTH):0] sp_o,
   output logic [3:0]             cs_o,
   output logic                   fault_o,
   output logic [1:0]             fault_code_o
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;

   localparam logic [SPW-1:0] SP_ONE  = SPW'(32'd1);
   localparam logic [SPW-1:0] SP_TWO  = SPW'(32'd2);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
   localparam logic [IW-1:0]  IDX_ONE = IW'(32'd1);
   localparam logic [IW-1:0]  IDX_TWO = IW'(32'd2);
   localparam logic [DW-1:0]  ZERO_W  = {DW{1'b0}};
   localparam logic [DW-1:0]  ONE_W   = {{(DW-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_HALT  = 4'h0;
   localparam logic [3:0] OP_PUSHI = 4'h1;
   localparam logic [3:0] OP_PUSH  = 4'h2;
   localparam logic [3:0] OP_POP   = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_JZ    = 4'h5;
   localparam logic [3:0] OP_JNZ   = 4'h6;
   localparam logic [3:0] OP_IN    = 4'h7;
   localparam logic [3:0] OP_OUT   = 4'h8;
   localparam logic [3:0] OP_OP    = 4'h9;
   localparam logic [3:0] OP_CALL  = 4'hA;
   localparam logic [3:0] OP_RET   = 4'hB;

   localparam logic [1:0] FC_NONE = 2'd0;
   localparam logic [1:0] FC_OVF  = 2'd1;
   localparam logic [1:0] FC_UNF  = 2'd2;
   localparam logic [1:0] FC_ILL  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCHA = 4'd1,
      S_FETCHB = 4'd2,
      S_EXECA  = 4'd3,
      S_EXECB  = 4'd4,
      S_HALT   = 4'd5,
      S_FAULT  = 4'd6
   } state_e;

   // architectural state
   state_e            state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [DW-1:0]     ir_q, ir_d;
   logic [SPW-1:0]    sp_q, sp_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              fault_q, fault_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic [DW-1:0]     stk_q [DEPTH];

   // single stack write port
   logic              stk_we_s;
   logic [IW-1:0]     stk_wa_s;
   logic [DW-1:0]     stk_wd_s;

   // decode and stack views
   logic [3:0]        opcode_s;
   logic [4:0]        func_s;
   logic [DW-1:0]     imm_s;
   logic [AW-1:0]     addr_s;
   logic              empty_s, has2_s, full_s;
   logic [IW-1:0]     push_idx_s, top_idx_s, nxt_idx_s;
   logic [DW-1:0]     qtop_s, qnext_s;
   logic [DW-1:0]     alu_res_s;
   logic              alu_ok_s;
   logic [1:0]        err_s;

   // memory / input handshake strobes
   logic [AW-1:0]     mem_addr_s;
   logic              mem_re_s, mem_we_s, in_ready_s;
   logic [DW-1:0]     mem_wdata_s;

   assign opcode_s   = ir_q[DW-1:DW-4];
   assign func_s     = ir_q[4:0];
   assign imm_s      = {{4{ir_q[DW-5]}}, ir_q[DW-5:0]};
   assign addr_s     = ir_q[AW-1:0];
   assign empty_s    = (sp_q == {SPW{1'b0}});
   assign has2_s     = (sp_q >= SP_TWO);
   assign full_s     = (sp_q == SP_FULL);
   assign push_idx_s = sp_q[IW-1:0];
   assign top_idx_s  = push_idx_s - IDX_ONE;
   assign nxt_idx_s  = push_idx_s - IDX_TWO;
   assign qtop_s     = empty_s ? ZERO_W : stk_q[top_idx_s];
   assign qnext_s    = has2_s ? stk_q[nxt_idx_s] : ZERO_W;

   // ALU: binary ops combine qnext with qtop, unary ops transform qtop
   always_comb begin
      alu_res_s = ZERO_W;
      alu_ok_s  = 1'b1;
      if (!func_s[4]) begin
         case (func_s[3:0])
            4'd0:    alu_res_s = qnext_s + qtop_s;
            4'd1:    alu_res_s = qnext_s - qtop_s;
            4'd2:    alu_res_s = qnext_s & qtop_s;
            4'd3:    alu_res_s = qnext_s | qtop_s;
            4'd4:    alu_res_s = qnext_s ^ qtop_s;
            4'd5:    alu_res_s = qnext_s << qtop_s[3:0];
            4'd6:    alu_res_s = qnext_s >> qtop_s[3:0];
            4'd7:    alu_res_s = ($signed(qnext_s) < $signed(qtop_s)) ? ONE_W : ZERO_W;
            default: alu_ok_s  = 1'b0;
         endcase
      end else begin
         case (func_s[3:0])
            4'd0:    alu_res_s = ~qtop_s;
            4'd1:    alu_res_s = ZERO_W - qtop_s;
            4'd2:    alu_res_s = qtop_s + ONE_W;
            4'd3:    alu_res_s = qtop_s - ONE_W;
            default: alu_ok_s  = 1'b0;
         endcase
      end
   end

   // fault classification of the instruction held in ir
   always_comb begin
      err_s = FC_NONE;
      case (opcode_s)
         OP_PUSHI, OP_PUSH, OP_IN, OP_CALL: begin
            if (full_s) err_s = FC_OVF;
            else        err_s = FC_NONE;
         end
         OP_POP, OP_JZ, OP_JNZ, OP_OUT, OP_RET: begin
            if (empty_s) err_s = FC_UNF;
            else         err_s = FC_NONE;
         end
         OP_OP: begin
            if (!alu_ok_s)            err_s = FC_ILL;
            else if (func_s[4])       err_s = empty_s ? FC_UNF : FC_NONE;
            else if (!has2_s)         err_s = FC_UNF;
            else                      err_s = FC_NONE;
         end
         OP_HALT, OP_JMP: err_s = FC_NONE;
         default:         err_s = FC_ILL;
      endcase
   end

   // next-state, stack update and memory/handshake strobes
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      sp_d         = sp_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q & ~out_ready_i;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      stk_we_s     = 1'b0;
      stk_wa_s     = push_idx_s;
      stk_wd_s     = ZERO_W;
      mem_addr_s   = pc_q;
      mem_re_s     = 1'b0;
      mem_we_s     = 1'b0;
      mem_wdata_s  = qtop_s;
      in_ready_s   = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (run_i) state_d = S_FETCHA;
            else       state_d = state_q;
         end
         S_FETCHA: begin
            mem_re_s = 1'b1;
            pc_d     = pc_q + {{(AW-1){1'b0}}, 1'b1};
            state_d  = S_FETCHB;
         end
         S_FETCHB: begin
            ir_d    = mem_rdata_i;
            state_d = S_EXECA;
         end
         S_EXECA: begin
            if (err_s != FC_NONE) begin
               // a faulting instruction leaves pc, stack and memory untouched
               state_d      = S_FAULT;
               fault_d      = 1'b1;
               fault_code_d = err_s;
            end else begin
               state_d = S_FETCHA;
               case (opcode_s)
                  OP_HALT: state_d = S_HALT;
                  OP_PUSHI: begin
                     stk_we_s = 1'b1;
                     stk_wd_s = imm_s;
                     sp_d     = sp_q + SP_ONE;
                  end
                  OP_PUSH: begin
                     mem_addr_s = addr_s;
                     mem_re_s   = 1'b1;
                     state_d    = S_EXECB;
                  end
                  OP_POP: begin
                     mem_addr_s = addr_s;
                     mem_we_s   = 1'b1;
                     sp_d       = sp_q - SP_ONE;
                  end
                  OP_JMP: pc_d = addr_s;
                  OP_JZ, OP_JNZ: begin
                     if ((qtop_s == ZERO_W) == (opcode_s == OP_JZ)) pc_d = addr_s;
                     else                                           pc_d = pc_q;
                     sp_d = sp_q - SP_ONE;
                  end
                  OP_IN: begin
                     in_ready_s = 1'b1;
                     if (in_valid_i) begin
                        stk_we_s = 1'b1;
                        stk_wd_s = in_data_i;
                        sp_d     = sp_q + SP_ONE;
                     end else begin
                        state_d = S_EXECA;
                     end
                  end
                  OP_OUT: begin
                     // reload wins over the clear from a same-cycle handshake
                     if (!out_valid_q || out_ready_i) begin
                        out_data_d  = qtop_s;
                        out_valid_d = 1'b1;
                        sp_d        = sp_q - SP_ONE;
                     end else begin
                        state_d = S_EXECA;
                     end
                  end
                  OP_OP: begin
                     stk_we_s = 1'b1;
                     stk_wd_s = alu_res_s;
                     if (func_s[4]) begin
                        stk_wa_s = top_idx_s;
                     end else begin
                        stk_wa_s = nxt_idx_s;
                        sp_d     = sp_q - SP_ONE;
                     end
                  end
                  OP_CALL: begin
                     stk_we_s = 1'b1;
                     stk_wd_s = {{(DW-AW){1'b0}}, pc_q};
                     sp_d     = sp_q + SP_ONE;
                     pc_d     = addr_s;
                  end
                  OP_RET: begin
                     pc_d = qtop_s[AW-1:0];
                     sp_d = sp_q - SP_ONE;
                  end
                  default: state_d = S_FAULT;
               endcase
            end
         end
         S_EXECB: begin
            stk_we_s = 1'b1;
            stk_wd_s = mem_rdata_i;
            sp_d     = sp_q + SP_ONE;
            state_d  = S_FETCHA;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         pc_q         <= {AW{1'b0}};
         ir_q         <= {DW{1'b0}};
         sp_q         <= {SPW{1'b0}};
         out_data_q   <= {DW{1'b0}};
         out_valid_q  <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) stk_q[i] <= {DW{1'b0}};
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         sp_q         <= sp_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         if (stk_we_s) stk_q[stk_wa_s] <= stk_wd_s;
      end
   end

   assign in_ready_o   = in_ready_s;
   assign out_data_o   = out_data_q;
   assign out_valid_o  = out_valid_q;
   assign mem_addr_o   = mem_addr_s;
   assign mem_re_o     = mem_re_s;
   assign mem_we_o     = mem_we_s;
   assign mem_wdata_o  = mem_wdata_s;
   assign pc_o         = pc_q;
   assign ir_o         = ir_q;
   assign qtop_o       = qtop_s;
   assign sp_o         = sp_q;
   assign cs_o         = state_q;
   assign fault_o      = fault_q;
   assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_stack_cpu_p.sv
// tb_stack_cpu_p: scenario tasks for stack_cpu_p at DW=16, AW=12, DEPTH=16.
// Expected output words go to a scoreboard queue as each program is set up;
// a negedge monitor records every delivered word for comparison.
module tb_stack_cpu_p;

   logic        clk = 1'b0;
   logic        rst_n, run, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid, mem_re, mem_we, fault;
   logic [15:0] out_data, mem_rdata, mem_wdata, ir, qtop;
   logic [11:0] mem_addr, pc;
   logic [4:0]  sp;
   logic [3:0]  cs;
   logic [1:0]  fault_code;

   always #5 clk = ~clk;

   stack_cpu_p #(.DW(16), .AW(12), .DEPTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata),
      .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
      .pc_o(pc), .ir_o(ir), .qtop_o(qtop), .sp_o(sp), .cs_o(cs),
      .fault_o(fault), .fault_code_o(fault_code)
   );

   // synchronous-read memory model with a bench loading port
   logic [15:0] mem [0:4095];
   logic        ld_we = 1'b0;
   logic [11:0] ld_addr;
   logic [15:0] ld_data;
   always @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // output monitor: records delivered words and strobe activity
   logic [15:0] obs_data [0:255];
   int obs_n = 0, ov_cycles = 0, we_cycles = 0;
   always @(negedge clk) begin
      if (out_valid && out_ready && obs_n < 256) begin
         obs_data[obs_n] = out_data;
         obs_n = obs_n + 1;
      end
      if (out_valid) ov_cycles = ov_cycles + 1;
      if (mem_we) we_cycles = we_cycles + 1;
   end

   logic [15:0] exp_q[$];
   logic [15:0] prog[$];
   int n_checks = 0, n_pass = 0;

   task automatic load_prog(input int base);
      for (int i = 0; i < prog.size(); i++) begin
         @(posedge clk); #1;
         ld_we = 1'b1; ld_addr = 12'(base + i); ld_data = prog[i];
         @(posedge clk); #1;
         ld_we = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_run();
      @(posedge clk); #1 run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
   endtask

   task automatic wait_cs(input logic [3:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (cs === target) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({pc, ir, sp, out_data, out_valid, fault, fault_code} !== '0)
         $display("FAIL reset_regs: got pc=%h ir=%h sp=%0d od=%h ov=%b f=%b fc=%0d want all 0",
                  pc, ir, sp, out_data, out_valid, fault, fault_code);
      else n_pass++;
      n_checks++;
      if ({mem_re, mem_we, in_ready, qtop} !== '0)
         $display("FAIL reset_strobes: got re=%b we=%b ir=%b qtop=%h want 0", mem_re, mem_we, in_ready, qtop);
      else n_pass++;
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cs !== 4'd0) $display("FAIL reset_idle: got cs=%0d want 0", cs); else n_pass++;
   endtask

   task automatic test_sub();
      bit ok; int ob, ov0, k; logic [15:0] e;
      prog = '{16'h1005, 16'h1003, 16'h9001, 16'h8000, 16'h0000};
      load_prog(0);
      do_reset();
      out_ready = 1'b1;
      ob = obs_n; ov0 = ov_cycles;
      exp_q.push_back(16'd2);
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++; if (!ok) $display("FAIL sub_halt: got cs=%0d want 5", cs); else n_pass++;
      n_checks++; if (sp !== 5'd0) $display("FAIL sub_sp: got %0d want 0", sp); else n_pass++;
      n_checks++; if (pc !== 12'd5) $display("FAIL sub_pc: got %0d want 5", pc); else n_pass++;
      n_checks++;
      if (ov_cycles - ov0 !== 1) $display("FAIL sub_ovcycles: got %0d want 1", ov_cycles - ov0); else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL sub_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL sub_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_alu();
      bit ok; int ob, k; logic [15:0] e;
      prog = '{16'h1FFF, 16'h0000, 16'h9011, 16'h0000, 16'h1FFE, 16'h1001, 16'h9007, 16'h0000,
               16'h1006, 16'h1003, 16'h9005, 16'h8000, 16'h1F00, 16'h1004, 16'h9006, 16'h8000,
               16'h1005, 16'h1003, 16'h9004, 16'h9012, 16'h8000, 16'h100C, 16'h100A, 16'h9002,
               16'h8000, 16'h100C, 16'h100A, 16'h9003, 16'h8000, 16'h1003, 16'h9010, 16'h8000,
               16'h1000, 16'h9013, 16'h8000, 16'h1009, 16'h100C, 16'h9001, 16'h8000, 16'h9000,
               16'h8000, 16'h1007, 16'h1002, 16'h9007, 16'h8000, 16'h0000};
      load_prog(0);
      do_reset();
      out_ready = 1'b1;
      ob = obs_n;
      exp_q = '{16'h0030, 16'h0FF0, 16'h0007, 16'h0008, 16'h000E,
                16'hFFFC, 16'hFFFF, 16'hFFFD, 16'h0002, 16'h0000};
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++; if (!ok || qtop !== 16'hFFFF) $display("FAIL alu_pushi_m1: got qtop=%h want ffff", qtop); else n_pass++;
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++; if (!ok || qtop !== 16'h0001) $display("FAIL alu_neg: got qtop=%h want 0001", qtop); else n_pass++;
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++;
      if (!ok || qtop !== 16'h0001 || sp !== 5'd2) $display("FAIL alu_lt_signed: got qtop=%h sp=%0d want 0001 sp=2", qtop, sp);
      else n_pass++;
      pulse_run();
      wait_cs(4'd5, 600, ok);
      n_checks++; if (!ok || sp !== 5'd0) $display("FAIL alu_end: got cs=%0d sp=%0d want 5/0", cs, sp); else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL alu_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL alu_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_in();
      bit ok, bad; int ob, k; logic [15:0] e;
      prog = '{16'h7000, 16'h8000, 16'h0000};
      load_prog(0);
      do_reset();
      out_ready = 1'b1; in_valid = 1'b0; in_data = 16'h0;
      ob = obs_n;
      exp_q.push_back(16'h1234);
      pulse_run();
      wait_cs(4'd3, 50, ok);
      n_checks++; if (!ok) $display("FAIL in_reach_exec: got cs=%0d want 3", cs); else n_pass++;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (cs !== 4'd3 || in_ready !== 1'b1) bad = 1'b1;
      end
      n_checks++; if (bad) $display("FAIL in_stall: got cs=%0d in_ready=%b want 3/1", cs, in_ready); else n_pass++;
      @(posedge clk); #1 in_valid = 1'b1; in_data = 16'h1234;
      @(posedge clk); #1 in_valid = 1'b0; in_data = 16'hDEAD;
      wait_cs(4'd5, 200, ok);
      n_checks++;
      if (!ok || sp !== 5'd0 || in_ready !== 1'b0) $display("FAIL in_end: got cs=%0d sp=%0d in_ready=%b want 5/0/0", cs, sp, in_ready);
      else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL in_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL in_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_back_to_back();
      bit ok, seen; int ob, k; logic [15:0] e;
      prog = '{16'h10AA, 16'h1055, 16'h8000, 16'h8000, 16'h0000};
      load_prog(0);
      do_reset();
      out_ready = 1'b0;
      ob = obs_n;
      exp_q = '{16'h0055, 16'h00AA};
      pulse_run();
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_checks++; if (!seen) $display("FAIL b2b_first_valid: got out_valid=%b want 1", out_valid); else n_pass++;
      repeat (4) @(negedge clk);
      n_checks++;
      if (cs !== 4'd3 || out_data !== 16'h0055 || out_valid !== 1'b1 || sp !== 5'd1 || obs_n !== ob)
         $display("FAIL b2b_stall: got cs=%0d od=%h ov=%b sp=%0d delivered=%0d want 3/0055/1/1/0",
                  cs, out_data, out_valid, sp, obs_n - ob);
      else n_pass++;
      @(posedge clk); #1 out_ready = 1'b1;
      wait_cs(4'd5, 200, ok);
      n_checks++; if (!ok || sp !== 5'd0) $display("FAIL b2b_end: got cs=%0d sp=%0d want 5/0", cs, sp); else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL b2b_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_call();
      bit ok; int ob, k; logic [15:0] e;
      prog = '{16'hA100, 16'h0000};
      load_prog(0);
      prog = '{16'h1007, 16'h8000, 16'hB000};
      load_prog(12'h100);
      do_reset();
      out_ready = 1'b1;
      ob = obs_n;
      exp_q.push_back(16'h0007);
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++;
      if (!ok || pc !== 12'd2 || sp !== 5'd0 || ir !== 16'h0000)
         $display("FAIL call_return: got cs=%0d pc=%h sp=%0d ir=%h want 5/002/0/0000", cs, pc, sp, ir);
      else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL call_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL call_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_mem();
      bit ok; int ob, we0, k; logic [15:0] e;
      prog = '{16'h1123, 16'h3200, 16'h2200, 16'h8000, 16'h0000};
      load_prog(0);
      do_reset();
      out_ready = 1'b1;
      ob = obs_n; we0 = we_cycles;
      exp_q.push_back(16'h0123);
      pulse_run();
      wait_cs(4'd5, 200, ok);
      n_checks++;
      if (!ok || sp !== 5'd0 || mem[12'h200] !== 16'h0123 || we_cycles - we0 !== 1)
         $display("FAIL mem_poppush: got cs=%0d sp=%0d mem=%h writes=%0d want 5/0/0123/1",
                  cs, sp, mem[12'h200], we_cycles - we0);
      else n_pass++;
      n_checks++;
      if (obs_n - ob !== exp_q.size()) $display("FAIL mem_count: got %0d want %0d", obs_n - ob, exp_q.size()); else n_pass++;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (ob + k >= obs_n || obs_data[ob + k] !== e)
            $display("FAIL mem_word%0d: got %h want %h", k, (ob + k < obs_n) ? obs_data[ob + k] : 16'hxxxx, e);
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_faults();
      bit ok; int we0;
      // POP on an empty stack
      prog = '{16'h3200};
      load_prog(0);
      do_reset();
      we0 = we_cycles;
      pulse_run();
      wait_cs(4'd6, 100, ok);
      n_checks++;
      if (!ok || fault !== 1'b1 || fault_code !== 2'd2 || we_cycles !== we0)
         $display("FAIL fault_pop_empty: got cs=%0d f=%b fc=%0d writes=%0d want 6/1/2/0", cs, fault, fault_code, we_cycles - we0);
      else n_pass++;
      // binary OP with one entry
      prog = '{16'h1001, 16'h9000};
      load_prog(0);
      do_reset();
      pulse_run();
      wait_cs(4'd6, 100, ok);
      n_checks++;
      if (!ok || fault_code !== 2'd2 || sp !== 5'd1 || qtop !== 16'h0001 || pc !== 12'd2)
         $display("FAIL fault_add_unf: got cs=%0d fc=%0d sp=%0d qtop=%h pc=%0d want 6/2/1/0001/2", cs, fault_code, sp, qtop, pc);
      else n_pass++;
      // illegal opcode, then run must be ignored
      prog = '{16'hC000};
      load_prog(0);
      do_reset();
      pulse_run();
      wait_cs(4'd6, 100, ok);
      n_checks++; if (!ok || fault_code !== 2'd3) $display("FAIL fault_illegal: got cs=%0d fc=%0d want 6/3", cs, fault_code); else n_pass++;
      pulse_run();
      repeat (3) @(negedge clk);
      n_checks++;
      if (cs !== 4'd6 || fault !== 1'b1) $display("FAIL fault_sticky: got cs=%0d f=%b want 6/1", cs, fault); else n_pass++;
      // undefined OP function code
      prog = '{16'h1001, 16'h1002, 16'h9008};
      load_prog(0);
      do_reset();
      pulse_run();
      wait_cs(4'd6, 100, ok);
      n_checks++;
      if (!ok || fault_code !== 2'd3 || sp !== 5'd2) $display("FAIL fault_bad_func: got cs=%0d fc=%0d sp=%0d want 6/3/2", cs, fault_code, sp);
      else n_pass++;
   endtask

   task automatic test_overflow_reset();
      bit ok, bad;
      prog.delete();
      for (int i = 0; i < 17; i++) prog.push_back(16'h1000 | 16'(i + 1));
      prog.push_back(16'h0000);
      load_prog(0);
      do_reset();
      pulse_run();
      wait_cs(4'd6, 500, ok);
      n_checks++;
      if (!ok || fault !== 1'b1 || fault_code !== 2'd1 || sp !== 5'd16 || qtop !== 16'h0010 || pc !== 12'd17)
         $display("FAIL ovf: got cs=%0d f=%b fc=%0d sp=%0d qtop=%h pc=%0d want 6/1/1/16/0010/17",
                  cs, fault, fault_code, sp, qtop, pc);
      else n_pass++;
      // reset in the middle of a fresh run
      do_reset();
      pulse_run();
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pc, ir, sp, out_data, out_valid, fault, fault_code, cs, mem_re, mem_we, in_ready, qtop} !== '0)
         $display("FAIL midrun_reset: got pc=%h ir=%h sp=%0d cs=%0d f=%b re=%b qtop=%h want all 0",
                  pc, ir, sp, cs, fault, mem_re, qtop);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (cs !== 4'd0) bad = 1'b1;
      end
      n_checks++; if (bad) $display("FAIL midrun_idle: got cs=%0d want 0", cs); else n_pass++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sub();
      test_alu();
      test_in();
      test_back_to_back();
      test_call();
      test_mem();
      test_faults();
      test_overflow_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
